// File: rtl/time_ascii_tx.sv
// Serialises a snapshot of the stopwatch as "HH:MM:SS" (plus optional CR LF)
// onto a valid/ready byte stream feeding the UART transmitter.
module time_ascii_tx #(
    parameter bit         SEND_CRLF = 1'b1,
    parameter logic [7:0] SEP_CHAR  = 8'h3A
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       send,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       dbg_state
);

    // Handshake: a byte transfers on any posedge where tx_valid && tx_ready.
    // Once raised, tx_valid and tx_data hold until that transfer happens.

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    localparam logic [3:0] LAST_IDX = SEND_CRLF ? 4'd9 : 4'd7;

    state_e     state_q, state_d;
    logic [3:0] index_q, index_d;
    logic [5:0] hr_q, hr_d;
    logic [5:0] mn_q, mn_d;
    logic [5:0] sc_q, sc_d;
    logic       pending_q, pending_d;
    logic       frame_done_q, frame_done_d;
    logic       accept;

    function automatic logic [7:0] tens_char(input logic [5:0] v);
        logic [5:0] t;
        t = v / 6'd10;
        return 8'h30 + {2'b00, t};
    endfunction

    function automatic logic [7:0] ones_char(input logic [5:0] v);
        logic [5:0] o;
        o = v % 6'd10;
        return 8'h30 + {2'b00, o};
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            index_q      <= 4'd0;
            hr_q         <= 6'd0;
            mn_q         <= 6'd0;
            sc_q         <= 6'd0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            hr_q         <= hr_d;
            mn_q         <= mn_d;
            sc_q         <= sc_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign accept = tx_valid && tx_ready;

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        hr_d         = hr_q;
        mn_d         = mn_q;
        sc_d         = sc_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A deferred request is served here, with a fresh snapshot.
                if (send || pending_q) begin
                    hr_d      = hours;
                    mn_d      = minutes;
                    sc_d      = seconds;
                    index_d   = 4'd0;
                    pending_d = 1'b0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (send) begin
                    pending_d = 1'b1;
                end
                if (accept) begin
                    if (index_q == LAST_IDX) begin
                        index_d      = 4'd0;
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        index_d = index_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        tx_valid   = (state_q == ST_SEND);
        busy       = (state_q == ST_SEND);
        frame_done = frame_done_q;
        dbg_state  = state_q;
        tx_data    = 8'h00;
        if (state_q == ST_SEND) begin
            case (index_q)
                4'd0:    tx_data = tens_char(hr_q);
                4'd1:    tx_data = ones_char(hr_q);
                4'd2:    tx_data = SEP_CHAR;
                4'd3:    tx_data = tens_char(mn_q);
                4'd4:    tx_data = ones_char(mn_q);
                4'd5:    tx_data = SEP_CHAR;
                4'd6:    tx_data = tens_char(sc_q);
                4'd7:    tx_data = ones_char(sc_q);
                4'd8:    tx_data = 8'h0D;
                4'd9:    tx_data = 8'h0A;
                default: tx_data = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_time_ascii_tx.sv
// Bench for time_ascii_tx: one instance with CR LF, one without, sharing the
// time inputs and tx_ready; a negedge monitor scores bytes against expected queues.
module tb_time_ascii_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] hours, minutes, seconds;
    logic       send, send8;
    logic       tx_ready;
    logic [7:0] tx_data, tx_data8;
    logic       tx_valid, tx_valid8, busy, busy8;
    logic       frame_done, frame_done8, dbg_state, dbg_state8;

    int total = 0;
    int bad   = 0;
    int ready_mode = 0;

    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];
    logic       exp_fd[2];
    logic       hold[2];
    logic [7:0] hold_d[2];

    always #5 clk = ~clk;

    time_ascii_tx #(.SEND_CRLF(1'b1), .SEP_CHAR(8'h3A)) dut (
        .clk(clk), .reset_n(reset_n), .hours(hours), .minutes(minutes),
        .seconds(seconds), .send(send), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done),
        .dbg_state(dbg_state)
    );

    time_ascii_tx #(.SEND_CRLF(1'b0), .SEP_CHAR(8'h3A)) dut8 (
        .clk(clk), .reset_n(reset_n), .hours(hours), .minutes(minutes),
        .seconds(seconds), .send(send8), .tx_data(tx_data8), .tx_valid(tx_valid8),
        .tx_ready(tx_ready), .busy(busy8), .frame_done(frame_done8),
        .dbg_state(dbg_state8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int w);
        return (w == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // Reference: the frame is just the decimal text of the snapshot.
    task automatic push_frame(input int w, input int h, input int m, input int s);
        string str;
        logic [8:0] e;
        str = $sformatf("%02d:%02d:%02d", h, m, s);
        for (int i = 0; i < str.len(); i++) begin
            e = {(w == 1 && i == str.len() - 1), str[i]};
            if (w == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
        if (w == 0) begin
            exp_q0.push_back({1'b0, 8'h0D});
            exp_q0.push_back({1'b1, 8'h0A});
        end
    endtask

    task automatic check_port(input int w, input logic v, input logic rdy, input logic rst_n,
                              input logic [7:0] d, input logic fd, input logic bsy);
        logic [8:0] e;
        logic       got;
        if (!rst_n) begin
            exp_fd[w] = 1'b0;
            hold[w]   = 1'b0;
            return;
        end
        if (fd || exp_fd[w]) begin
            check($sformatf("frame_done dut%0d", w), {31'd0, fd}, {31'd0, exp_fd[w]});
            if (exp_fd[w]) check($sformatf("idle_after_frame dut%0d", w), {30'd0, v, bsy}, 32'd0);
        end
        exp_fd[w] = 1'b0;
        if (hold[w]) check($sformatf("stall_hold dut%0d", w), {23'd0, v, d}, {23'd0, 1'b1, hold_d[w]});
        hold[w] = 1'b0;
        if (v && rdy) begin
            got = 1'b0;
            e   = 9'd0;
            if (w == 0 && exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                got = 1'b1;
            end else if (w == 1 && exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                got = 1'b1;
            end
            if (!got) begin
                total++;
                bad++;
                $display("FAIL unexpected_byte dut%0d: got %02h expected none", w, d);
            end else begin
                check($sformatf("tx_data dut%0d", w), {24'd0, d}, {24'd0, e[7:0]});
                exp_fd[w] = e[8];
            end
        end else if (v) begin
            hold[w]   = 1'b1;
            hold_d[w] = d;
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        check_port(0, tx_valid, tx_ready, reset_n, tx_data, frame_done, busy);
        check_port(1, tx_valid8, tx_ready, reset_n, tx_data8, frame_done8, busy8);
    end

    // tx_ready driver: 0 = held high, 1 = random, 2 = 1-0-0-1 pattern
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: begin
                    tx_ready = (ph % 4 == 0) || (ph % 4 == 3);
                    ph++;
                end
            endcase
        end
    end

    task automatic set_time(input int h, input int m, input int s);
        hours   = h[5:0];
        minutes = m[5:0];
        seconds = s[5:0];
    endtask

    task automatic do_send(input int w, input bit chk_lat);
        if (w == 0) send = 1'b1;
        else        send8 = 1'b1;
        @(posedge clk);
        #1;
        send  = 1'b0;
        send8 = 1'b0;
        if (chk_lat)
            check($sformatf("first_byte_latency dut%0d", w),
                  (w == 0) ? {30'd0, tx_valid, busy} : {30'd0, tx_valid8, busy8}, 32'd3);
    endtask

    task automatic start_frame(input int w, input int h, input int m, input int s);
        set_time(h, m, s);
        push_frame(w, h, m, s);
        do_send(w, 1'b1);
    endtask

    task automatic wait_idle(input int w);
        int n;
        n = 0;
        while ((qsize(w) != 0 || ((w == 0) ? busy : busy8)) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL idle_timeout dut%0d: %0d bytes still expected", w, qsize(w));
            exp_q0.delete();
            exp_q1.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int h, m, s, w;
        reset_n  = 1'b0;
        send     = 1'b0;
        send8    = 1'b0;
        tx_ready = 1'b1;
        set_time(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs dut0", {20'd0, tx_valid, busy, frame_done, dbg_state, tx_data}, 32'd0);
        check("reset_outputs dut1", {20'd0, tx_valid8, busy8, frame_done8, dbg_state8, tx_data8}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // T1: back-to-back bytes at full rate
        start_frame(0, 1, 2, 3);
        repeat (10) @(posedge clk);
        #1;
        check("t1_frame_done_timing", {29'd0, frame_done, busy, tx_valid}, 32'd4);
        check("t1_queue_drained", exp_q0.size(), 32'd0);
        wait_idle(0);

        // T6: no CR LF, 8 bytes
        start_frame(1, 63, 0, 9);
        repeat (8) @(posedge clk);
        #1;
        check("t6_frame_done_timing", {29'd0, frame_done8, busy8, tx_valid8}, 32'd4);
        check("t6_queue_drained", exp_q1.size(), 32'd0);
        wait_idle(1);

        // T2: stalls with the 1-0-0-1 ready pattern
        ready_mode = 2;
        start_frame(0, 23, 59, 59);
        wait_idle(0);

        // T4: inputs change mid-frame
        ready_mode = 1;
        start_frame(0, 12, 34, 56);
        repeat (2) @(posedge clk);
        #1;
        set_time(33, 44, 55);
        wait_idle(0);

        // T3: two sends mid-frame; only the first is kept
        start_frame(0, 4, 5, 6);
        repeat (3) @(posedge clk);
        #1;
        set_time(0, 0, 5);
        push_frame(0, 0, 0, 5);
        do_send(0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        do_send(0, 1'b0);
        wait_idle(0);

        // send in the same cycle as the last acceptance
        ready_mode = 0;
        @(posedge clk);
        #1;
        start_frame(0, 40, 41, 42);
        repeat (9) @(posedge clk);
        #1;
        set_time(7, 8, 9);
        push_frame(0, 7, 8, 9);
        send = 1'b1;
        @(posedge clk);
        #1;
        send = 1'b0;
        check("edge_send_gap_cycle", {30'd0, frame_done, tx_valid}, 32'd2);
        repeat (11) @(posedge clk);
        #1;
        check("edge_send_second_frame_done", {31'd0, frame_done}, 32'd1);
        check("edge_send_queue_drained", exp_q0.size(), 32'd0);
        wait_idle(0);

        // T5: reset after the fourth byte
        start_frame(0, 11, 22, 33);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        exp_q0.delete();
        @(posedge clk);
        #1;
        check("t5_reset_abort", {21'd0, tx_valid, busy, frame_done, tx_data}, 32'd0);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("t5_stays_idle", {30'd0, tx_valid, busy}, 32'd0);

        // Randomised frames with random back-pressure and pending requests
        ready_mode = 1;
        for (int it = 0; it < 24; it++) begin
            w = $urandom_range(0, 1);
            h = $urandom_range(0, 63);
            m = $urandom_range(0, 63);
            s = $urandom_range(0, 63);
            start_frame(w, h, m, s);
            if (w == 0) begin
                repeat ($urandom_range(0, 5)) @(posedge clk);
                #1;
                h = $urandom_range(0, 63);
                m = $urandom_range(0, 63);
                s = $urandom_range(0, 63);
                set_time(h, m, s);
                if ($urandom_range(0, 1) == 1) begin
                    push_frame(0, h, m, s);
                    do_send(0, 1'b0);
                    if ($urandom_range(0, 1) == 1) do_send(0, 1'b0);
                end
            end
            wait_idle(w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
